// File: rtl/result_sender_pkg.sv
// Shared constants and state encoding for the result transmit path.
// The state type is also consumed by the I/O controller for debug visibility.
package result_sender_pkg;

    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_RD,
        SEND,
        WAIT_ACK,
        DONE
    } rs_state_t;

endpackage

// File: rtl/result_sender_byte_deconcat.sv
// Word-to-byte shift register: loads a memory word, presents its low byte,
// and shifts right one byte at a time while tracking the byte position.
module byte_deconcat #(
    parameter int DATAW = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [DATAW-1:0] i_word,
    input  logic             i_shift,
    output logic [7:0]       o_byte,
    output logic             o_last
);

    localparam int BYTES = DATAW / 8;
    localparam int BIW   = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [DATAW-1:0] r_sreg;
    logic [BIW-1:0]   r_byte_idx;

    // A load restarts the byte position so the word goes out LSB first.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sreg     <= '0;
            r_byte_idx <= '0;
        end else if (i_load) begin
            r_sreg     <= i_word;
            r_byte_idx <= '0;
        end else if (i_shift) begin
            r_sreg     <= r_sreg >> 8;
            r_byte_idx <= r_byte_idx + 1'b1;
        end
    end

    assign o_byte = r_sreg[7:0];
    assign o_last = (r_byte_idx == BIW'(BYTES - 1));

endmodule

// File: rtl/result_sender.sv
// result_sender: reads result words from data memory and streams their bytes,
// LSB first, to the AXI UART TX channel; pulses done when nbytes have gone out.
module result_sender
    import result_sender_pkg::*;
#(
    parameter int ADDRW  = 12,
    parameter int DATAW  = 8 * BYTES_PER_WORD,
    parameter int RD_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [31:0]      i_nbytes,
    input  logic [ADDRW-1:0] i_base_addr,
    output logic             o_mem_re,
    output logic [ADDRW-1:0] o_mem_addr,
    input  logic [DATAW-1:0] i_mem_rdata,
    output logic             o_axi_we,
    output logic [7:0]       o_axi_wdata,
    input  logic             i_axi_w_busy,
    input  logic             i_axi_w_success,
    output logic             o_busy,
    output logic             o_done
);

    localparam int LATW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    rs_state_t        r_state;
    rs_state_t        w_state_n;
    logic [31:0]      r_remaining;
    logic [ADDRW-1:0] r_word_idx;
    logic [ADDRW-1:0] r_base;
    logic [LATW-1:0]  r_rd_cnt;

    logic             w_rd_last;
    logic             w_load;
    logic             w_shift;
    logic             w_byte_last;
    logic [7:0]       w_byte;

    assign w_rd_last = (r_rd_cnt == LATW'(RD_LAT - 1));
    assign w_load    = (r_state == WAIT_RD) && w_rd_last;
    assign w_shift   = (r_state == WAIT_ACK) && i_axi_w_success;

    byte_deconcat #(
        .DATAW (DATAW)
    ) u_deconcat (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_word  (i_mem_rdata),
        .i_shift (w_shift),
        .o_byte  (w_byte),
        .o_last  (w_byte_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    // Success wins over a simultaneous busy; the last-byte test precedes the
    // end-of-word test so a finished transfer never issues an extra read.
    always_comb begin
        w_state_n = r_state;
        o_mem_re  = 1'b0;
        o_axi_we  = 1'b0;
        o_done    = 1'b0;
        o_busy    = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_n = (i_nbytes == 32'd0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                o_mem_re  = 1'b1;
                w_state_n = WAIT_RD;
            end
            WAIT_RD: begin
                if (w_rd_last) begin
                    w_state_n = SEND;
                end
            end
            SEND: begin
                if (!i_axi_w_busy) begin
                    w_state_n = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                o_axi_we = 1'b1;
                if (i_axi_w_success) begin
                    if (r_remaining == 32'd1) begin
                        w_state_n = DONE;
                    end else if (w_byte_last) begin
                        w_state_n = FETCH;
                    end else begin
                        w_state_n = SEND;
                    end
                end
            end
            DONE: begin
                o_done    = 1'b1;
                w_state_n = IDLE;
            end
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_remaining <= '0;
            r_word_idx  <= '0;
            r_base      <= '0;
            r_rd_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start && (i_nbytes != 32'd0)) begin
                        r_remaining <= i_nbytes;
                        r_word_idx  <= '0;
                        r_base      <= i_base_addr;
                    end
                end
                FETCH: r_rd_cnt <= '0;
                WAIT_RD: begin
                    r_rd_cnt <= r_rd_cnt + 1'b1;
                    if (w_rd_last) begin
                        r_word_idx <= r_word_idx + 1'b1;
                    end
                end
                WAIT_ACK: begin
                    if (i_axi_w_success) begin
                        r_remaining <= r_remaining - 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Word offset wraps naturally at the address width.
    assign o_mem_addr  = r_base + r_word_idx;
    assign o_axi_wdata = w_byte;

endmodule

// File: tb/tb_result_sender.sv
// Self-checking bench for result_sender: a pipelined memory, a responsive
// TX channel and a byte-stream reference model derived from memory contents.
module tb_result_sender;

    localparam int ADDRW  = 12;
    localparam int DATAW  = 32;
    localparam int RD_LAT = 2;
    localparam int BYTES  = DATAW / 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             iStart = 1'b0;
    logic [31:0]      iNbytes = '0;
    logic [ADDRW-1:0] iBaseAddr = '0;
    logic             oMemRe;
    logic [ADDRW-1:0] oMemAddr;
    logic             oAxiWe;
    logic [7:0]       oAxiWdata;
    logic             axiWBusy = 1'b0;
    logic             axiWSuccess = 1'b0;
    logic             oBusy;
    logic             oDone;

    logic [DATAW-1:0] mem [0:(1<<ADDRW)-1];
    logic [DATAW-1:0] rdPipe1 = '0;
    logic [DATAW-1:0] rdPipe2 = '0;

    int vecCnt = 0;
    int errCnt = 0;
    int cyc = 0;
    int startCyc = 0;

    logic [7:0]       gotBytes [$];
    logic [ADDRW-1:0] reAddrs [$];
    int doneCnt, doneCyc, firstWeCyc, firstReCyc, weTotal, stableViol, busyViol;

    int cfgAck = 1;
    int cfgHold = 0;
    bit cfgBusyAck = 1'b0;
    bit cfgRnd = 1'b0;
    bit cfgSpur = 1'b0;

    int         weCnt = 0;
    int         gapCnt = 0;
    logic       prevBusy = 1'b0;
    logic [7:0] prevData = '0;
    logic       sNow;

    result_sender #(
        .ADDRW  (ADDRW),
        .DATAW  (DATAW),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_start         (iStart),
        .i_nbytes        (iNbytes),
        .i_base_addr     (iBaseAddr),
        .o_mem_re        (oMemRe),
        .o_mem_addr      (oMemAddr),
        .i_mem_rdata     (rdPipe2),
        .o_axi_we        (oAxiWe),
        .o_axi_wdata     (oAxiWdata),
        .i_axi_w_busy    (axiWBusy),
        .i_axi_w_success (axiWSuccess),
        .o_busy          (oBusy),
        .o_done          (oDone)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory with RD_LAT = 2: address captured, then data presented one cycle later.
    always @(posedge clk) begin
        rdPipe1 <= mem[oMemAddr];
        rdPipe2 <= rdPipe1;
    end

    // TX channel responder and event recorder, working on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                weCnt       = 0;
                gapCnt      = 0;
                axiWSuccess = 1'b0;
                axiWBusy    = 1'b0;
                prevBusy    = 1'b0;
            end else begin
                if (oMemRe) begin
                    reAddrs.push_back(oMemAddr);
                    if (firstReCyc < 0) firstReCyc = cyc;
                end
                if (oDone) begin
                    doneCnt++;
                    doneCyc = cyc;
                end
                if (oAxiWe) begin
                    weCnt++;
                    weTotal++;
                    if (weCnt == 1) begin
                        if (prevBusy) busyViol++;
                        if (firstWeCyc < 0) firstWeCyc = cyc;
                    end else if (oAxiWdata !== prevData) begin
                        stableViol++;
                    end
                    prevData = oAxiWdata;
                    sNow = (weCnt == cfgAck);
                    if (sNow) gotBytes.push_back(oAxiWdata);
                    axiWSuccess = sNow;
                    axiWBusy    = cfgBusyAck;
                    gapCnt      = 0;
                end else begin
                    weCnt = 0;
                    if (oBusy) begin
                        gapCnt++;
                        axiWBusy = (gapCnt <= cfgHold) || (cfgRnd && ($urandom_range(0, 2) == 0));
                    end else begin
                        gapCnt   = 0;
                        axiWBusy = 1'b0;
                    end
                    axiWSuccess = cfgSpur ? 1'($urandom_range(0, 1)) : 1'b0;
                end
                prevBusy = axiWBusy;
            end
        end
    end

    function automatic logic [7:0] modelByte(input logic [ADDRW-1:0] base, input int idx);
        logic [ADDRW-1:0] a;
        logic [DATAW-1:0] w;
        a = base + ADDRW'(idx / BYTES);
        w = mem[a];
        return w[8*(idx % BYTES) +: 8];
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vecCnt++;
        assert (observed === expected)
        else begin
            errCnt++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic startTransfer(input logic [ADDRW-1:0] base, input int n);
        @(posedge clk);
        #1;
        gotBytes.delete();
        reAddrs.delete();
        doneCnt    = 0;
        doneCyc    = -1;
        firstWeCyc = -1;
        firstReCyc = -1;
        weTotal    = 0;
        stableViol = 0;
        busyViol   = 0;
        iStart     = 1'b1;
        iNbytes    = n;
        iBaseAddr  = base;
        startCyc   = cyc;
        @(posedge clk);
        #1;
        iStart = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        int guard;
        guard = 0;
        while (doneCnt == 0 && guard < budget) begin
            @(posedge clk);
            #1;
            guard++;
        end
        checkOutput("done_timeout", 64'(doneCnt != 0), 64'd1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [ADDRW-1:0] base, input int n, input int ack,
                                 input int hold, input bit busyAck, input bit rnd,
                                 input bit spur, input bit junk);
        cfgAck     = ack;
        cfgHold    = hold;
        cfgBusyAck = busyAck;
        cfgRnd     = rnd;
        cfgSpur    = spur;
        startTransfer(base, n);
        if (junk) begin
            repeat (2) @(posedge clk);
            #1;
            iStart    = 1'b1;
            iNbytes   = $urandom_range(1, 40);
            iBaseAddr = ADDRW'($urandom);
            @(posedge clk);
            #1;
            iStart = 1'b0;
        end
        waitDone(3000);
    endtask

    task automatic checkTransfer(input logic [ADDRW-1:0] base, input int n, input bit latency);
        logic [ADDRW-1:0] a;
        checkOutput("done_count", 64'(doneCnt), 64'd1);
        checkOutput("byte_count", 64'(gotBytes.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            if (i < gotBytes.size())
                checkOutput($sformatf("byte%0d", i), 64'(gotBytes[i]), 64'(modelByte(base, i)));
        end
        checkOutput("read_count", 64'(reAddrs.size()), 64'((n + BYTES - 1) / BYTES));
        for (int k = 0; k < reAddrs.size(); k++) begin
            a = base + ADDRW'(k);
            checkOutput($sformatf("read_addr%0d", k), 64'(reAddrs[k]), 64'(a));
        end
        checkOutput("busy_after", 64'(oBusy), 64'd0);
        checkOutput("wdata_stable", 64'(stableViol), 64'd0);
        checkOutput("we_under_busy", 64'(busyViol), 64'd0);
        checkOutput("we_cycles", 64'(weTotal), 64'(n * cfgAck));
        if (n == 0) begin
            checkOutput("zero_done_lat", 64'(doneCyc - startCyc), 64'd1);
        end else if (latency) begin
            checkOutput("first_re_lat", 64'(firstReCyc - startCyc), 64'd1);
            checkOutput("first_we_lat", 64'(firstWeCyc - startCyc), 64'(1 + (1 + RD_LAT + 1)));
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_mem_re"}, 64'(oMemRe), 64'd0);
        checkOutput({tag, "_mem_addr"}, 64'(oMemAddr), 64'd0);
        checkOutput({tag, "_axi_we"}, 64'(oAxiWe), 64'd0);
        checkOutput({tag, "_axi_wdata"}, 64'(oAxiWdata), 64'd0);
        checkOutput({tag, "_busy"}, 64'(oBusy), 64'd0);
        checkOutput({tag, "_done"}, 64'(oDone), 64'd0);
    endtask

    initial begin
        int guard;
        int n;
        logic [ADDRW-1:0] base;

        for (int i = 0; i < (1 << ADDRW); i++) mem[i] = $urandom;
        mem[12'h010] = 32'h44332211;
        mem[12'h011] = 32'h88776655;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset");
        rst = 1'b0;

        $display("[TB] basic two-word transfer");
        applyStimulus(12'h010, 8, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkTransfer(12'h010, 8, 1'b1);

        $display("[TB] partial last word");
        applyStimulus(12'h010, 5, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkTransfer(12'h010, 5, 1'b1);

        $display("[TB] zero length");
        applyStimulus(12'h010, 0, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkTransfer(12'h010, 0, 1'b1);

        $display("[TB] backpressure");
        applyStimulus(12'h010, 4, 1, 10, 1'b0, 1'b0, 1'b0, 1'b0);
        checkTransfer(12'h010, 4, 1'b0);

        $display("[TB] slow acknowledge with busy");
        applyStimulus(12'h010, 4, 7, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkTransfer(12'h010, 4, 1'b1);

        $display("[TB] start while busy");
        applyStimulus(12'h010, 8, 1, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkTransfer(12'h010, 8, 1'b1);

        $display("[TB] address wrap");
        applyStimulus(12'hFFF, 6, 2, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkTransfer(12'hFFF, 6, 1'b1);

        $display("[TB] randomized transfers");
        for (int t = 0; t < 6; t++) begin
            base = ADDRW'($urandom);
            n    = $urandom_range(1, 13);
            applyStimulus(base, n, $urandom_range(1, 4), 0, 1'($urandom_range(0, 1)),
                          1'b1, 1'b1, 1'b0);
            checkTransfer(base, n, 1'b0);
        end

        $display("[TB] reset mid-transfer");
        cfgAck = 1; cfgHold = 0; cfgBusyAck = 1'b0; cfgRnd = 1'b0; cfgSpur = 1'b0;
        startTransfer(12'h020, 12);
        guard = 0;
        while (gotBytes.size() < 3 && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        checkOutput("three_bytes_timeout", 64'(gotBytes.size() >= 3), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkAllZero("midreset");
        rst = 1'b0;
        applyStimulus(12'h010, 4, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkTransfer(12'h010, 4, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
        $finish;
    end

endmodule
